uart_xcvr: RTL and testbench

Parametrised, synthesizable UART transceiver for the SoC user area. Successor to the fixed 9600-baud, 8N1 bench UART. Adds:
- a runtime baud divider and an oversampled, mid-bit-sampling receiver;
- configurable data width, parity and stop bits;
- valid/ready handshakes on both directions, an RX FIFO, and per-frame error reporting.

Sits between the Wishbone-side UART register block and the `ser_tx`/`ser_rx` pads.

---
 rtl/uart_xcvr.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr.sv
// UART transceiver: runtime baud divider, oversampled mid-bit receiver,
// configurable parity/stop bits, valid/ready handshakes and an RX FIFO.
module uart_xcvr #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int RX_DEPTH   = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             ser_tx,
    input  logic             ser_rx,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_frame_err,
    output logic             rx_parity_err,
    output logic             rx_overrun
);
    localparam int OSW = $clog2(2 * OVERSAMPLE);
    localparam int AW  = $clog2(RX_DEPTH);
    localparam int EW  = DATA_BITS + 2;
    localparam logic [OSW-1:0] OS_FULL = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_DBL  = OSW'(2 * OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DIV_W-1:0] div_eff;
    assign div_eff = (clk_div == '0) ? DIV_W'(1) : clk_div;

    // ---------------- transmitter ----------------
    state_t           tx_state, tx_next;
    logic [DIV_W-1:0] tx_div, tx_cnt;
    logic [OSW-1:0]   tx_os, tx_os_last;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_sh;
    logic             tx_par, tx_pen, tx_two;
    logic             tx_tick, tx_end, tx_acc;

    assign tx_tick    = (tx_cnt == tx_div - DIV_W'(1));
    assign tx_os_last = (tx_state == S_STOP && tx_two) ? OS_DBL : OS_FULL;
    assign tx_end     = tx_tick && (tx_os == tx_os_last);
    // Ready during the final stop cycle lets the next frame follow gaplessly.
    assign tx_ready   = (tx_state == S_IDLE) || (tx_state == S_STOP && tx_end);
    assign tx_acc     = tx_valid && tx_ready;

    always_comb begin
        tx_next = tx_state;
        ser_tx  = 1'b1;
        unique case (tx_state)
            S_IDLE:  if (tx_valid) tx_next = S_START;
            S_START: begin
                ser_tx = 1'b0;
                if (tx_end) tx_next = S_DATA;
            end
            S_DATA: begin
                ser_tx = tx_sh[0];
                if (tx_end && tx_bit == BIT_LAST)
                    tx_next = tx_pen ? S_PAR : S_STOP;
            end
            S_PAR: begin
                ser_tx = tx_par;
                if (tx_end) tx_next = S_STOP;
            end
            S_STOP:  if (tx_end) tx_next = tx_valid ? S_START : S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) tx_state <= S_IDLE;
        else          tx_state <= tx_next;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_div <= DIV_W'(1);
            tx_cnt <= '0;
            tx_os  <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
            tx_pen <= 1'b0;
            tx_two <= 1'b0;
        end else if (tx_acc) begin
            tx_div <= div_eff;
            tx_pen <= parity_en;
            tx_two <= two_stop;
            tx_par <= (^tx_data[DATA_BITS-1:0]) ^ parity_odd;
            tx_sh  <= tx_data;
            tx_cnt <= '0;
            tx_os  <= '0;
            tx_bit <= '0;
        end else if (tx_state != S_IDLE) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                if (tx_os == tx_os_last) begin
                    tx_os <= '0;
                    if (tx_state == S_DATA) begin
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx_bit <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_os <= tx_os + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    state_t               rx_state, rx_next;
    logic                 rx_s1, rx_s2, rx_prev;
    logic [DIV_W-1:0]     rx_div, rx_cnt;
    logic [OSW-1:0]       rx_os, rx_os_last;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_acc_par, rx_pen, rx_odd;
    logic                 rx_tick, rx_samp, rx_start, rx_push;
    logic [EW-1:0]        rx_entry;

    assign rx_start   = (rx_state == S_IDLE) && rx_prev && !rx_s2;
    assign rx_os_last = (rx_state == S_START) ? OS_HALF : OS_FULL;
    assign rx_tick    = (rx_cnt == rx_div - DIV_W'(1));
    assign rx_samp    = (rx_state != S_IDLE) && rx_tick && (rx_os == rx_os_last);
    assign rx_entry   = {!rx_s2, rx_pen && (rx_acc_par != rx_odd), rx_sh};

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        unique case (rx_state)
            S_IDLE:  if (rx_start) rx_next = S_START;
            S_START: if (rx_samp) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_samp && rx_bit == BIT_LAST)
                         rx_next = rx_pen ? S_PAR : S_STOP;
            S_PAR:   if (rx_samp) rx_next = S_STOP;
            S_STOP: begin
                if (rx_samp) begin
                    rx_push = 1'b1;
                    rx_next = S_IDLE;
                end
            end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_state <= S_IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_state <= rx_next;
            rx_s1    <= ser_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_div     <= DIV_W'(1);
            rx_cnt     <= '0;
            rx_os      <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_acc_par <= 1'b0;
            rx_pen     <= 1'b0;
            rx_odd     <= 1'b0;
        end else if (rx_start) begin
            rx_div     <= div_eff;
            rx_pen     <= parity_en;
            rx_odd     <= parity_odd;
            rx_cnt     <= '0;
            rx_os      <= '0;
            rx_bit     <= '0;
            rx_acc_par <= 1'b0;
        end else if (rx_state != S_IDLE) begin
            if (rx_tick) begin
                rx_cnt <= '0;
                if (rx_samp) begin
                    rx_os <= '0;
                    if (rx_state == S_DATA) begin
                        rx_sh      <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                        rx_bit     <= rx_bit + 3'd1;
                        rx_acc_par <= rx_acc_par ^ rx_s2;
                    end else if (rx_state == S_PAR) begin
                        rx_acc_par <= rx_acc_par ^ rx_s2;
                    end
                end else begin
                    rx_os <= rx_os + 1'b1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX FIFO (first-word-fall-through) ----------------
    logic [EW-1:0] mem [RX_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          full, pop, wr;
    logic [EW-1:0] head;

    assign full     = (cnt == (AW+1)'(RX_DEPTH));
    assign rx_valid = (cnt != '0);
    assign pop      = rx_valid && rx_ready;
    assign wr       = rx_push && (!full || pop);
    assign head     = mem[rp];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_push && full && !pop;
            if (wr)  wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            unique case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr) mem[wp] <= rx_entry;
    end

    always_comb begin
        rx_data = '0;
        if (rx_valid) rx_data[DATA_BITS-1:0] = head[DATA_BITS-1:0];
    end

    assign rx_frame_err  = rx_valid && head[EW-1];
    assign rx_parity_err = rx_valid && head[EW-2];
endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr: TX waveform, loopback, RX error table,
// FIFO overrun, glitch rejection, async reset and a 5-bit instance.
module tb_uart_xcvr;
    localparam int B = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clk_div;
    logic        parity_en, parity_odd, two_stop;
    logic        tx_valid, tx_ready, ser_tx;
    logic [7:0]  tx_data;
    logic        rx_drv = 1'b1, lpbk = 1'b0, ser_rx;
    logic        rx_valid, rx_ready, rx_fe, rx_pe, rx_ovr;
    logic [7:0]  rx_data;
    logic        tx_valid5, tx_ready5, ser_tx5;
    logic        rx_valid5, rx_ready5, rx_fe5, rx_pe5, rx_ovr5;
    logic [7:0]  rx_data5;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    int cyc = 0;

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_exp_t;
    rx_exp_t sb[$];

    typedef struct {
        logic [7:0] d;
        logic       pen;
        logic       odd;
        logic       bad_par;
        logic       bad_stop;
        logic [7:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;
    vec_t vt[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ser_rx = lpbk ? ser_tx : rx_drv;

    uart_xcvr dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .clk_div(clk_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .ser_tx(ser_tx), .ser_rx(ser_rx),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_frame_err(rx_fe), .rx_parity_err(rx_pe), .rx_overrun(rx_ovr)
    );

    uart_xcvr #(.DATA_BITS(5)) dut5 (
        .wb_clk_i(clk), .wb_rst_i(rst), .clk_div(clk_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .tx_valid(tx_valid5), .tx_ready(tx_ready5), .tx_data(tx_data),
        .ser_tx(ser_tx5), .ser_rx(ser_tx5),
        .rx_valid(rx_valid5), .rx_ready(rx_ready5), .rx_data(rx_data5),
        .rx_frame_err(rx_fe5), .rx_parity_err(rx_pe5), .rx_overrun(rx_ovr5)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: each popped head is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rx_ovr) ovr_cnt++;
        if (!rst && rx_valid && rx_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected actual=%h required=none",
                         {rx_fe, rx_pe, rx_data});
            end else begin
                rx_exp_t e;
                e = sb.pop_front();
                if ({rx_fe, rx_pe, rx_data} !== e) begin
                    failures++;
                    $display("FAIL rx_pop actual=%h required=%h",
                             {rx_fe, rx_pe, rx_data}, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_send(input logic [7:0] d, output int acc);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            tick(1);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            failures++;
            $display("FAIL tx_accept_timeout actual=%0d required=<2000", n);
        end
        @(posedge clk);
        acc = cyc;
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic rx_bang(input logic [7:0] d, input logic pen,
                           input logic odd, input logic bad_par,
                           input logic bad_stop);
        logic p;
        p = (^d) ^ odd ^ bad_par;
        rx_drv = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(B);
        end
        if (pen) begin
            rx_drv = p;
            tick(B);
        end
        rx_drv = !bad_stop;
        tick(B);
        rx_drv = 1'b1;
        tick(2 * B);
    endtask

    task automatic wait_sb_empty(input string nm, input int lim);
        int n;
        n = 0;
        while (sb.size() != 0 && n < lim) begin
            tick(1);
            n++;
        end
        check(nm, sb.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, low, bad, zeros, n;
        logic [9:0] fb;

        vt[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vt[1] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0};
        vt[2] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
        vt[3] = '{8'hC5, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC5, 1'b0, 1'b0};
        vt[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        clk_div    = 16'd2;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        rx_ready   = 1'b1;
        tx_valid5  = 1'b0;
        rx_ready5  = 1'b0;

        #12;
        check("rst_tx", {ser_tx, tx_ready}, 2'b11);
        check("rst_rx", {rx_valid, rx_data, rx_fe, rx_pe, rx_ovr}, 12'h000);
        tick(3);
        rst = 1'b0;
        tick(5);

        // 8N1 0x55: level per bit and ready-low span
        fb  = {1'b1, 8'h55, 1'b0};
        low = 0;
        tx_send(8'h55, a1);
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < B; c++) begin
                if (ser_tx !== fb[k]) bad++;
                if (tx_ready === 1'b0) low++;
                tick(1);
            end
            check($sformatf("tx55_bit%0d_badcycles", k), bad, 0);
        end
        check("tx55_ready_low", low, B * 10 - 1);
        check("tx55_idle_after", {ser_tx, tx_ready}, 2'b11);

        // Loopback 8E2, back-to-back
        lpbk       = 1'b1;
        parity_en  = 1'b1;
        two_stop   = 1'b1;
        sb.push_back('{1'b0, 1'b0, 8'hA3});
        sb.push_back('{1'b0, 1'b0, 8'h00});
        tx_send(8'hA3, a1);
        tx_send(8'h00, a2);
        check("tx_b2b_gap", a2 - a1, B * 12);
        wait_sb_empty("lpbk_drain", 1500);
        n = 0;
        while (!tx_ready && n < 1000) begin
            tick(1);
            n++;
        end
        check("lpbk_tx_idle", tx_ready, 1'b1);
        tick(4);
        lpbk      = 1'b0;
        parity_en = 1'b0;
        two_stop  = 1'b0;

        // RX error/parity table
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{vt[i].exp_fe, vt[i].exp_pe, vt[i].exp_d});
            parity_en  = vt[i].pen;
            parity_odd = vt[i].odd;
            rx_bang(vt[i].d, vt[i].pen, vt[i].odd, vt[i].bad_par,
                    vt[i].bad_stop);
        end
        wait_sb_empty("table_drain", 200);
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Overrun: four fit, the fifth is dropped
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) sb.push_back('{1'b0, 1'b0, 8'(k)});
            rx_bang(8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 4) check("ovr_before5", ovr_cnt, 0);
        end
        check("ovr_once", ovr_cnt, 1);
        check("ovr_full_valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        wait_sb_empty("ovr_drain", 50);
        tick(2);
        check("ovr_empty", rx_valid, 1'b0);

        // Short low glitch is a false start
        rx_ready = 1'b0;
        rx_drv   = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(3 * B);
        check("glitch_no_push", rx_valid, 1'b0);
        rx_ready = 1'b1;

        // 5-bit instance loopback with 0xFF
        tx_data   = 8'hFF;
        tx_valid5 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid5 = 1'b0;
        low   = 0;
        zeros = 0;
        for (int c = 0; c < 7 * B; c++) begin
            if (ser_tx5 === 1'b0) zeros++;
            if (tx_ready5 === 1'b0) low++;
            tick(1);
        end
        check("db5_start_only_low", zeros, B);
        check("db5_ready_low", low, 7 * B - 1);
        n = 0;
        while (!rx_valid5 && n < 500) begin
            tick(1);
            n++;
        end
        check("db5_rx_valid", rx_valid5, 1'b1);
        check("db5_rx_data", {rx_fe5, rx_pe5, rx_data5}, 10'h01F);

        // Async reset in the middle of a TX frame
        tx_send(8'h00, a1);
        tick(100);
        check("midtx_low", ser_tx, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx", {ser_tx, tx_ready}, 2'b11);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("rst_tx_idle", {ser_tx, tx_ready}, 2'b11);

        // Reset during a partial RX frame discards it
        rx_ready = 1'b0;
        rx_drv   = 1'b0;
        tick(3 * B);
        rst = 1'b1;
        tick(1);
        rx_drv = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(12 * B);
        check("rst_rx_discard", rx_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
